// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction-fetch stage: datapath width default,
// next-PC select encodings, reset/trap vector defaults and a helper that sizes
// the occupancy counters.
// No ports (package).
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int          DEFAULT_XLEN     = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0100;
    localparam int          DEFAULT_IQ_DEPTH = 4;

    // Next-PC source; any non-sequential value is a redirect.
    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_JUMP   = 2'b01,
        PC_BRANCH = 2'b10,
        PC_TRAP   = 2'b11
    } pc_sel_e;

    // Counter width able to hold 0..depth inclusive.
    function automatic int ctr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles the instruction-memory request/response channel and the
// fetch-to-decode channel of the fetch stage.
//   master : the fetch unit (drives imem request, decode-side instruction)
//   slave  : the environment (memory + decode)
// Signals:
//   imem_req_valid / imem_req_ready / imem_addr   request channel
//   imem_resp_valid / imem_resp_data              in-order response, no stall
//   if_valid / if_ready / if_instr / if_pc        instruction to decode
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int XLEN = fetch_unit_pkg::DEFAULT_XLEN
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;

    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output if_valid, if_instr, if_pc,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  if_valid, if_instr, if_pc,
        output if_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// DEPTH-entry in-order instruction queue. An entry is reserved (tagged with its
// PC) when a request issues, filled when its response returns, and popped by
// decode once full. Three pointers: reserve (tail), fill, head.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   i_flush         invalidate every entry, reserved or full
//   i_reserve/i_res_pc      allocate tail entry with PC tag
//   i_fill/i_fill_data      write oldest unfilled reserved entry
//   i_deq           pop head (ignored unless head is full)
//   o_no_slot       all DEPTH entries reserved
//   o_head_valid/o_head_pc/o_head_instr   head entry to decode
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int XLEN  = DEFAULT_XLEN,
    parameter int DEPTH = DEFAULT_IQ_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_flush,
    input  logic            i_reserve,
    input  logic [XLEN-1:0] i_res_pc,
    input  logic            i_fill,
    input  logic [XLEN-1:0] i_fill_data,
    input  logic            i_deq,
    output logic            o_no_slot,
    output logic            o_head_valid,
    output logic [XLEN-1:0] o_head_pc,
    output logic [XLEN-1:0] o_head_instr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = ctr_width(DEPTH);

    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic [XLEN-1:0] r_instr_mem [DEPTH];
    logic            r_full      [DEPTH];
    logic [PW-1:0]   r_res_ptr;
    logic [PW-1:0]   r_fill_ptr;
    logic [PW-1:0]   r_head_ptr;
    logic [CW-1:0]   r_count;      // reserved entries, filled or not

    logic w_do_reserve;
    logic w_do_fill;
    logic w_do_deq;

    // A flush drops everything, so reserve/fill that cycle must not land.
    // A dequeue in the flush cycle still counts as accepted by decode.
    assign w_do_reserve = i_reserve & ~i_flush;
    assign w_do_fill    = i_fill & ~i_flush;
    assign w_do_deq     = i_deq & o_head_valid;

    assign o_no_slot    = (r_count == CW'(DEPTH));
    assign o_head_valid = r_full[r_head_ptr];
    assign o_head_pc    = r_pc_mem[r_head_ptr];
    assign o_head_instr = r_instr_mem[r_head_ptr];

    // Payload storage carries no reset; the full flags gate its use.
    always_ff @(posedge clk) begin
        if (w_do_reserve) begin
            r_pc_mem[r_res_ptr] <= i_res_pc;
        end
        if (w_do_fill) begin
            r_instr_mem[r_fill_ptr] <= i_fill_data;
        end
    end

    // Per-entry full flag. Fill only ever targets a reserved, unfilled entry,
    // and dequeue only a full one, so the two never collide on one slot.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_full
            always_ff @(posedge clk) begin
                if (reset || i_flush) begin
                    r_full[gi] <= 1'b0;
                end else if (w_do_fill && (r_fill_ptr == PW'(gi))) begin
                    r_full[gi] <= 1'b1;
                end else if ((w_do_deq && (r_head_ptr == PW'(gi))) ||
                             (w_do_reserve && (r_res_ptr == PW'(gi)))) begin
                    r_full[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_res_ptr  <= '0;
            r_fill_ptr <= '0;
            r_head_ptr <= '0;
            r_count    <= '0;
        end else begin
            if (w_do_reserve) r_res_ptr  <= r_res_ptr + PW'(1);
            if (w_do_fill)    r_fill_ptr <= r_fill_ptr + PW'(1);
            if (w_do_deq)     r_head_ptr <= r_head_ptr + PW'(1);
            r_count <= r_count + CW'(w_do_reserve) - CW'(w_do_deq);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: PC register, next-PC mux (sequential / jump /
// branch / trap), in-order request issue, in-flight and drop counters, and an
// IQ_DEPTH-entry queue pairing each returned instruction with its PC.
// Responses belonging to requests issued before a redirect are discarded.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   pc_sel            00 seq, 01 jump, 10 branch, 11 trap (nonzero = redirect)
//   jump_target       target for pc_sel = 01
//   branch_target     target for pc_sel = 10
//   fbus              fetch_unit_if.master: imem request/response + decode
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] TRAP_VEC = DEFAULT_TRAP_VEC,
    parameter int              IQ_DEPTH = DEFAULT_IQ_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        pc_sel,
    input  logic [XLEN-1:0]   jump_target,
    input  logic [XLEN-1:0]   branch_target,
    fetch_unit_if.master      fbus
);
    localparam int CW = ctr_width(IQ_DEPTH);

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_drop_cnt;

    logic [XLEN-1:0] w_pc_next;
    logic [CW-1:0]   w_inflight_next;
    logic            w_redirect;
    logic            w_no_slot;
    logic            w_req_valid;
    logic            w_fire;
    logic            w_resp_fill;
    logic            w_head_valid;
    logic [XLEN-1:0] w_head_pc;
    logic [XLEN-1:0] w_head_instr;

    assign w_redirect  = (pc_sel != PC_SEQ);
    assign w_req_valid = ~w_redirect & ~w_no_slot & (r_inflight < CW'(IQ_DEPTH));
    assign w_fire      = w_req_valid & fbus.imem_req_ready;

    // Only responses for post-redirect requests may fill the queue; anything
    // arriving during a redirect is stale by definition.
    assign w_resp_fill = fbus.imem_resp_valid & ~w_redirect & (r_drop_cnt == '0);

    // Every response retires one in-flight request, dropped or not.
    assign w_inflight_next = r_inflight + CW'(w_fire) - CW'(fbus.imem_resp_valid);

    always_comb begin
        w_pc_next = r_pc;
        case (pc_sel_e'(pc_sel))
            PC_JUMP:   w_pc_next = jump_target;
            PC_BRANCH: w_pc_next = branch_target;
            PC_TRAP:   w_pc_next = TRAP_VEC;
            default: begin
                if (w_fire) begin
                    w_pc_next = r_pc + XLEN'(4);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_pc       <= w_pc_next;
            r_inflight <= w_inflight_next;
            if (w_redirect) begin
                // Everything still outstanding after this cycle is stale,
                // including requests already marked for dropping.
                r_drop_cnt <= r_inflight - CW'(fbus.imem_resp_valid);
            end else if (fbus.imem_resp_valid && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

    fetch_queue #(
        .XLEN  (XLEN),
        .DEPTH (IQ_DEPTH)
    ) u_queue (
        .clk          (clk),
        .reset        (reset),
        .i_flush      (w_redirect),
        .i_reserve    (w_fire),
        .i_res_pc     (r_pc),
        .i_fill       (w_resp_fill),
        .i_fill_data  (fbus.imem_resp_data),
        .i_deq        (fbus.if_ready),
        .o_no_slot    (w_no_slot),
        .o_head_valid (w_head_valid),
        .o_head_pc    (w_head_pc),
        .o_head_instr (w_head_instr)
    );

    assign fbus.imem_req_valid = w_req_valid;
    assign fbus.imem_addr      = r_pc;
    assign fbus.if_valid       = w_head_valid;
    assign fbus.if_pc          = w_head_pc;
    assign fbus.if_instr       = w_head_instr;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage for the pipelined RISC-V core. It owns the program counter, selects the next PC from the sequential, jump, branch or trap source, and issues in-order requests to instruction memory over a valid/ready interface. Returned instructions are buffered, paired with their PC, in an IQ_DEPTH-entry queue that feeds decode. Stale responses are discarded after any redirect.

## Interface
- XLEN, 32, datapath width (PC, addresses, instructions)
- RESET_PC, 32'h0000_0000, PC value after reset
- TRAP_VEC, 32'h0000_0100, redirect target for pc_sel = 2'b11
- IQ_DEPTH, 4, instruction-queue entries; power of two, ≥ 2

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- pc_sel  in  2  00 sequential, 01 jump, 10 branch, 11 trap; nonzero means redirect
- jump_target  in  XLEN  target used when pc_sel = 01
- branch_target  in  XLEN  target used when pc_sel = 10
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  XLEN  request address (= PC register)
- imem_resp_valid  in  1  response valid; responses return in request order, no backpressure
- imem_resp_data  in  XLEN  instruction word
- if_valid  out  1  queue head holds a returned instruction
- if_ready  in  1  decode accepts the head
- if_instr  out  XLEN  head instruction
- if_pc  out  XLEN  PC of the head instruction

## Operation
- Request fire = imem_req_valid & imem_req_ready. On fire, the unit reserves a queue entry tagged with its PC, and pc <= pc + 4 (mod 2^XLEN, wraps silently).
- imem_req_valid = !redirect & (reserved entries < IQ_DEPTH) & (inflight < IQ_DEPTH).
- A response with drop_cnt = 0 writes its data into the oldest reserved entry that has no data and marks that entry full.
- A response with drop_cnt > 0 is discarded and decrements drop_cnt.
- if_valid = the head entry is full. Dequeue happens on if_valid & if_ready.
- Redirect (pc_sel ≠ 00):
  - pc <= selected target.
  - All queue entries are invalidated, including reserved ones.
  - drop_cnt <= inflight − (imem_resp_valid ? 1 : 0). This includes responses that were already marked for dropping.
  - No request issues in the redirect cycle.
  - A response arriving in the redirect cycle is discarded.
- Redirect has priority over fire and response. A dequeue handshake in the redirect cycle still completes.
- inflight counter: +1 on fire, −1 on response. Width is clog2(IQ_DEPTH)+1. It never exceeds IQ_DEPTH.
- Targets are not alignment-checked.

## Timing
- Reset values: pc = RESET_PC, queue empty, inflight = 0, drop_cnt = 0.
- Outputs after reset: if_valid = 0. imem_req_valid = 1 from the first cycle after reset deasserts. imem_addr = RESET_PC.
- Reset mid-operation returns all state to the reset values. Any later responses to pre-reset requests are the memory's responsibility (the memory must be reset alongside this unit).
- Sequential throughput: one request per cycle when memory is always ready and decode is always ready.
- Latency: response at cycle t gives if_valid at t+1 (registered queue). Response-to-decode latency is therefore 1 cycle.
- Redirect at cycle t: imem_addr = target and imem_req_valid = 1 at t+1. The earliest if_valid for the target is one cycle after its response.
- Full queue: imem_req_valid = 0. It reasserts the cycle after a dequeue frees a slot.
- Dequeue and response to the same slot in the same cycle are both legal. Queue pointers wrap modulo IQ_DEPTH.

## Structure
- Shared core package holds:
  - XLEN default
  - pc_sel encodings: PC_SEQ = 2'b00, PC_JUMP = 2'b01, PC_BRANCH = 2'b10, PC_TRAP = 2'b11
  - RESET_PC / TRAP_VEC defaults
- One sub-module, fetch_queue, holds:
  - IQ_DEPTH entries of {pc, instr, full}
  - reserve, fill and dequeue pointers
  - flush input
- fetch_unit contains the PC register, next-PC mux, inflight/drop counters and request logic.

## Test plan
- Reset, memory and decode always ready, 1-cycle memory returning addr as data:
  - imem_addr sequence 0, 4, 8, 12.
  - if_pc/if_instr pairs (0,0), (4,4), … on consecutive cycles.
- Decode stalled (if_ready = 0), IQ_DEPTH = 4:
  - Exactly 4 requests issue, then imem_req_valid stays 0.
  - One dequeue gives exactly one new request, at address 16.
- Jump with pc_sel = 01, jump_target = 32'h200, while 2 requests are in flight:
  - No request in the redirect cycle.
  - Next imem_addr = 32'h200.
  - Both old responses are discarded.
  - First if_pc = 32'h200.
- Branch (10) and trap (11) back to back on consecutive cycles:
  - Final PC = TRAP_VEC (32'h100).
  - No instruction from the branch target reaches decode.
- Response arrives in the same cycle as a redirect, with 3 in flight:
  - drop_cnt = 2.
  - Exactly 2 further responses are dropped.
  - The next response fills the target entry.
- PC wrap: reset with RESET_PC = 32'hFFFF_FFFC gives requests at FFFF_FFFC then 0000_0000.
